// File: rtl/decode_stage_pipe_pkg.sv
// Shared decode definitions for decode_stage_pipe: opcodes, ALU operations,
// the control bundle carried into EX and the opcode decoder.
package decode_pkg;

  localparam logic [4:0] OP_NOP  = 5'h00;
  localparam logic [4:0] OP_ADD  = 5'h08;
  localparam logic [4:0] OP_LDM  = 5'h0C;
  localparam logic [4:0] OP_LDD  = 5'h14;
  localparam logic [4:0] OP_STD  = 5'h15;
  localparam logic [4:0] OP_PUSH = 5'h10;
  localparam logic [4:0] OP_POP  = 5'h11;

  typedef enum logic [3:0] {
    ALU_NOP  = 4'h0,
    ALU_ADD  = 4'h1,
    ALU_SUB  = 4'h2,
    ALU_AND  = 4'h3,
    ALU_OR   = 4'h4,
    ALU_PASS = 4'h5
  } alu_op_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic       wb;
    alu_op_t    alu_op;
    logic       alu_src_imm;
    logic       one_operand;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       push;
    logic       pop;
    logic       in_port;
    logic       out_port;
    logic [2:0] jump_type;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  // Loads/stores address memory as rs2 + imm; rs1 is the data register.
  function automatic ctrl_t ctrl_decode(input logic [4:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_ADD: begin
        c.wb       = 1'b1;
        c.alu_op   = ALU_ADD;
        c.uses_rs1 = 1'b1;
        c.uses_rs2 = 1'b1;
      end
      OP_LDM: begin
        c.wb          = 1'b1;
        c.alu_op      = ALU_PASS;
        c.alu_src_imm = 1'b1;
        c.one_operand = 1'b1;
      end
      OP_LDD: begin
        c.mem_read    = 1'b1;
        c.wb          = 1'b1;
        c.alu_op      = ALU_ADD;
        c.alu_src_imm = 1'b1;
        c.uses_rs2    = 1'b1;
      end
      OP_STD: begin
        c.mem_write   = 1'b1;
        c.alu_op      = ALU_ADD;
        c.alu_src_imm = 1'b1;
        c.uses_rs1    = 1'b1;
        c.uses_rs2    = 1'b1;
      end
      OP_PUSH: begin
        c.mem_write   = 1'b1;
        c.push        = 1'b1;
        c.one_operand = 1'b1;
        c.uses_rs1    = 1'b1;
      end
      OP_POP: begin
        c.mem_read    = 1'b1;
        c.wb          = 1'b1;
        c.pop         = 1'b1;
        c.one_operand = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Bus between IF/ID, the WB stage and the ID/EX register of decode_stage_pipe.
// master = decode stage side, slave = surrounding pipeline.
interface decode_stage_pipe_if #(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3
);
  import decode_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instruction;
  logic               flush;
  logic               wb_en;
  logic [REG_AW-1:0]  wb_addr;
  logic [DATA_W-1:0]  wb_data;
  logic               stall;
  logic               ex_valid;
  ctrl_t              ex_ctrl;
  logic [DATA_W-1:0]  ex_rs1_data;
  logic [DATA_W-1:0]  ex_rs2_data;
  logic [DATA_W-1:0]  ex_imm;
  logic [REG_AW-1:0]  ex_rd;
  logic [REG_AW-1:0]  ex_rs1;
  logic [REG_AW-1:0]  ex_rs2;

  modport master (
    input  instr_valid, instruction, flush, wb_en, wb_addr, wb_data,
    output stall, ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rd, ex_rs1, ex_rs2
  );

  modport slave (
    output instr_valid, instruction, flush, wb_en, wb_addr, wb_data,
    input  stall, ex_valid, ex_ctrl, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rd, ex_rs1, ex_rs2
  );

endinterface

// File: rtl/decode_stage_pipe_regfile.sv
// 2-read/1-write register file with synchronous clear.
// Define WB_BYPASS_EN to make the read ports return same-cycle write data.
module regfile_2r1w #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);
  localparam int NREG = 1 << REG_AW;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

`ifdef WB_BYPASS_EN
  // Write-first: a register being written this cycle reads as its new value.
  assign rdata1 = (we && (waddr == raddr1)) ? wdata : regs[raddr1];
  assign rdata2 = (we && (waddr == raddr2)) ? wdata : regs[raddr2];
`else
  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
`endif

endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage with ID/EX register and load-use bubble insertion.
// Optional WB_BYPASS_EN macro enables write-first register file reads.
module decode_stage_pipe
  import decode_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int INSTR_W = 16,
  parameter int REG_AW  = 3,
  parameter int OPC_W   = 5,
  parameter int IMM_W   = 8
) (
  input logic           clk,
  input logic           reset,
  decode_stage_pipe_if.master bus
);

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic [IMM_W-1:0]  imm;
  logic [DATA_W-1:0] imm_ext;
  logic [DATA_W-1:0] rs1_data;
  logic [DATA_W-1:0] rs2_data;
  ctrl_t             ctrl;
  logic              hazard_rs1;
  logic              hazard_rs2;

  assign opcode  = bus.instruction[INSTR_W-1 -: OPC_W];
  assign rs1     = bus.instruction[INSTR_W-OPC_W-1 -: REG_AW];
  assign rs2     = bus.instruction[INSTR_W-OPC_W-REG_AW-1 -: REG_AW];
  assign imm     = bus.instruction[IMM_W-1:0];
  assign imm_ext = {{(DATA_W-IMM_W){1'b0}}, imm};

  always_comb begin
    ctrl = '0;
    ctrl = ctrl_decode(opcode);
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.wb_en),
    .waddr  (bus.wb_addr),
    .wdata  (bus.wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  // A load in EX cannot forward in time to a dependent instruction in ID.
  assign hazard_rs1 = ctrl.uses_rs1 && (rs1 == bus.ex_rd);
  assign hazard_rs2 = ctrl.uses_rs2 && (rs2 == bus.ex_rd);
  assign bus.stall  = bus.instr_valid && bus.ex_valid && bus.ex_ctrl.mem_read &&
                      bus.ex_ctrl.wb && (hazard_rs1 || hazard_rs2);

  always_ff @(posedge clk) begin
    if (reset || bus.flush || bus.stall) begin
      bus.ex_valid    <= 1'b0;
      bus.ex_ctrl     <= '0;
      bus.ex_rs1_data <= '0;
      bus.ex_rs2_data <= '0;
      bus.ex_imm      <= '0;
      bus.ex_rd       <= '0;
      bus.ex_rs1      <= '0;
      bus.ex_rs2      <= '0;
    end else begin
      bus.ex_valid    <= bus.instr_valid;
      bus.ex_ctrl     <= bus.instr_valid ? ctrl : '0;
      bus.ex_rs1_data <= rs1_data;
      bus.ex_rs2_data <= rs2_data;
      bus.ex_imm      <= imm_ext;
      bus.ex_rd       <= rs1;
      bus.ex_rs1      <= rs1;
      bus.ex_rs2      <= rs2;
    end
  end

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed scoreboard bench for decode_stage_pipe; expected ID/EX contents are
// queued as each step is driven and compared one cycle later.
module tb_decode_stage_pipe;
  import decode_pkg::*;

  typedef struct {
    logic        valid;
    ctrl_t       ctrl;
    logic [15:0] rs1_data;
    logic [15:0] rs2_data;
    logic [15:0] imm;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t sb[$];
  ctrl_t add_ctrl;
  ctrl_t ldd_ctrl;

  decode_stage_pipe_if #(.DATA_W(16), .INSTR_W(16), .REG_AW(3)) bus ();

  decode_stage_pipe #(
    .DATA_W (16), .INSTR_W (16), .REG_AW (3), .OPC_W (5), .IMM_W (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [4:0] op, input logic [2:0] r1,
                                      input logic [2:0] r2, input logic [4:0] lo);
    return {op, r1, r2, lo};
  endfunction

  function automatic exp_t bubble();
    exp_t e;
    e.valid = 1'b0; e.ctrl = '0; e.rs1_data = '0; e.rs2_data = '0;
    e.imm = '0; e.rd = '0; e.rs1 = '0; e.rs2 = '0;
    return e;
  endfunction

  function automatic exp_t live(input ctrl_t c, input logic [15:0] d1, input logic [15:0] d2,
                                input logic [15:0] im, input logic [2:0] r1, input logic [2:0] r2);
    exp_t e;
    e.valid = 1'b1; e.ctrl = c; e.rs1_data = d1; e.rs2_data = d2;
    e.imm = im; e.rd = r1; e.rs1 = r1; e.rs2 = r2;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    exp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed 0 expected 1");
      return;
    end
    e = sb.pop_front();
    check_val("ex_valid",    32'(bus.ex_valid),    32'(e.valid));
    check_val("ex_ctrl",     32'(bus.ex_ctrl),     32'(e.ctrl));
    check_val("ex_rs1_data", 32'(bus.ex_rs1_data), 32'(e.rs1_data));
    check_val("ex_rs2_data", 32'(bus.ex_rs2_data), 32'(e.rs2_data));
    check_val("ex_imm",      32'(bus.ex_imm),      32'(e.imm));
    check_val("ex_rd",       32'(bus.ex_rd),       32'(e.rd));
    check_val("ex_rs1",      32'(bus.ex_rs1),      32'(e.rs1));
    check_val("ex_rs2",      32'(bus.ex_rs2),      32'(e.rs2));
  endtask

  // One pipeline cycle: drive inputs, check stall, queue expectation, clock, compare.
  task automatic apply_stimulus(input logic rst, input logic v, input logic [15:0] ins,
                                input logic fl, input logic we, input logic [2:0] wa,
                                input logic [15:0] wd, input logic exp_stall, input exp_t e);
    reset           = rst;
    bus.instr_valid = v;
    bus.instruction = ins;
    bus.flush       = fl;
    bus.wb_en       = we;
    bus.wb_addr     = wa;
    bus.wb_data     = wd;
    #1;
    check_val("stall", 32'(bus.stall), 32'(exp_stall));
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_output();
  endtask

  initial begin
    logic [15:0] add12, ldd3, add43, add45, add61, bad;
    logic [15:0] r6_exp;
    clk = 1'b0; checks = 0; errors = 0;
    reset = 1'b1;
    bus.instr_valid = 1'b0; bus.instruction = '0; bus.flush = 1'b0;
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;

    add_ctrl = '0;
    add_ctrl.wb = 1'b1; add_ctrl.alu_op = ALU_ADD;
    add_ctrl.uses_rs1 = 1'b1; add_ctrl.uses_rs2 = 1'b1;
    ldd_ctrl = '0;
    ldd_ctrl.mem_read = 1'b1; ldd_ctrl.wb = 1'b1; ldd_ctrl.alu_op = ALU_ADD;
    ldd_ctrl.alu_src_imm = 1'b1; ldd_ctrl.uses_rs2 = 1'b1;

    add12 = enc(5'h08, 3'd1, 3'd2, 5'd0);   // 16'h4140
    ldd3  = enc(5'h14, 3'd3, 3'd5, 5'd4);   // 16'hA3A4
    add43 = enc(5'h08, 3'd4, 3'd3, 5'd0);   // 16'h4460
    add45 = enc(5'h08, 3'd4, 3'd5, 5'd0);   // 16'h44A0
    add61 = enc(5'h08, 3'd6, 3'd1, 5'd0);   // 16'h4620
    bad   = enc(5'h1F, 3'd2, 3'd0, 5'd0);   // 16'hFA00
`ifdef WB_BYPASS_EN
    r6_exp = 16'hBEEF;
`else
    r6_exp = 16'h0000;
`endif

    @(posedge clk); #1;
    $display("[TB] reset and register preload");
    apply_stimulus(1, 0, 16'h0, 0, 0, 3'd0, 16'h0,  0, bubble());
    apply_stimulus(0, 0, 16'h0, 0, 1, 3'd1, 16'h5,  0, bubble());
    apply_stimulus(0, 0, 16'h0, 0, 1, 3'd2, 16'h7,  0, bubble());

    $display("[TB] ADD R1,R2 then LDD/ADD load-use");
    apply_stimulus(0, 1, add12, 0, 1, 3'd3, 16'h22, 0, live(add_ctrl, 16'h5,  16'h7,  16'h40, 3'd1, 3'd2));
    apply_stimulus(0, 1, ldd3,  0, 1, 3'd4, 16'h11, 0, live(ldd_ctrl, 16'h22, 16'h0,  16'hA4, 3'd3, 3'd5));
    apply_stimulus(0, 1, add43, 0, 0, 3'd0, 16'h0,  1, bubble());
    apply_stimulus(0, 1, add43, 0, 0, 3'd0, 16'h0,  0, live(add_ctrl, 16'h11, 16'h22, 16'h60, 3'd4, 3'd3));

    $display("[TB] LDD then independent ADD");
    apply_stimulus(0, 1, ldd3,  0, 0, 3'd0, 16'h0,  0, live(ldd_ctrl, 16'h22, 16'h0,  16'hA4, 3'd3, 3'd5));
    apply_stimulus(0, 1, add45, 0, 0, 3'd0, 16'h0,  0, live(add_ctrl, 16'h11, 16'h0,  16'hA0, 3'd4, 3'd5));

    $display("[TB] flush, and flush together with stall");
    apply_stimulus(0, 1, add12, 1, 0, 3'd0, 16'h0,  0, bubble());
    apply_stimulus(0, 1, ldd3,  0, 0, 3'd0, 16'h0,  0, live(ldd_ctrl, 16'h22, 16'h0,  16'hA4, 3'd3, 3'd5));
    apply_stimulus(0, 1, add43, 1, 0, 3'd0, 16'h0,  1, bubble());
    apply_stimulus(0, 1, add43, 0, 0, 3'd0, 16'h0,  0, live(add_ctrl, 16'h11, 16'h22, 16'h60, 3'd4, 3'd3));

    $display("[TB] same-cycle write-back read");
    apply_stimulus(0, 1, add61, 0, 1, 3'd6, 16'hBEEF, 0, live(add_ctrl, r6_exp,  16'h5, 16'h20, 3'd6, 3'd1));
    apply_stimulus(0, 1, add61, 0, 0, 3'd0, 16'h0,    0, live(add_ctrl, 16'hBEEF, 16'h5, 16'h20, 3'd6, 3'd1));

    $display("[TB] reset mid-stream with concurrent write-back");
    apply_stimulus(1, 1, add12, 0, 1, 3'd1, 16'h99, 0, bubble());
    apply_stimulus(0, 1, add12, 0, 0, 3'd0, 16'h0,  0, live(add_ctrl, 16'h0, 16'h0, 16'h40, 3'd1, 3'd2));

    $display("[TB] unknown opcode decodes as NOP");
    apply_stimulus(0, 1, bad,   0, 0, 3'd0, 16'h0,  0, live('0, 16'h0, 16'h0, 16'h00, 3'd2, 3'd0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
